cache_wb_buffer: RTL and testbench

- Write-back eviction buffer directly downstream of the cache's LRU victim selection.
- Accepts dirty victim lines, with their line address, that the cache controller pulls out of the selected way.
- Queues them in a small FIFO and drains them to the memory write port over a valid/ready handshake.
- Exposes a combinational address lookup so a refill miss can be serviced from a still-queued victim, avoiding a stale read from memory.

---
 rtl/cache_pkg.sv | 14 +
 rtl/wb_lookup.sv | 31 +++
 rtl/cache_wb_buffer.sv | 109 ++++++++++
 tb/tb_cache_wb_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and the entry layout for the cache write-back buffer.
package cache_pkg;

    localparam int LINE_WIDTH  = 512;
    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = 6;
    localparam int TAG_W       = ADDR_WIDTH - OFFSET_BITS;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [LINE_WIDTH-1:0] line;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Newest-first tag match over the occupied write-back entries; returns a one-hot select.
module wb_lookup #(
    parameter int DEPTH = 4,
    parameter int TAG_W = cache_pkg::TAG_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
    input  logic [DEPTH-1:0]            occ_i,
    input  logic [PTR_W-1:0]            wr_ptr_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        hit_o,
    output logic [DEPTH-1:0]            sel_o
);

    logic [PTR_W-1:0] idx;

    // Walk from wr_ptr-1 backwards so the youngest matching entry is taken first.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr_i - PTR_W'(k + 1);
            if (!hit_o && occ_i[idx] && (tags_i[idx] == tag_i)) begin
                hit_o      = 1'b1;
                sel_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_wb_buffer.sv
// Dirty-victim FIFO between LRU eviction and the memory write port, with a
// combinational lookup so refills can be served from still-queued victims.
module cache_wb_buffer #(
    parameter int LINE_WIDTH  = cache_pkg::LINE_WIDTH,
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS,
    parameter int DEPTH       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      evict_valid_i,
    output logic                      evict_ready_o,
    input  logic                      evict_dirty_i,
    input  logic [ADDR_WIDTH-1:0]     evict_addr_i,
    input  logic [LINE_WIDTH-1:0]     evict_line_i,
    output logic                      mem_wr_valid_o,
    input  logic                      mem_wr_ready_i,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr_o,
    output logic [LINE_WIDTH-1:0]     mem_wr_data_o,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
    output logic                      lookup_hit_o,
    output logic [LINE_WIDTH-1:0]     lookup_line_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      full_o
);

    import cache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t                   entries_q [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        enq, deq;
    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic [DEPTH-1:0]            occ;
    logic [DEPTH-1:0]            sel;
    logic [PTR_W-1:0]            age;
    logic                        unused_offsets;

    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign evict_ready_o  = !full_o;
    assign mem_wr_valid_o = !empty_o;

    // Clean victims finish the handshake without consuming a slot.
    assign enq = evict_valid_i && evict_ready_o && evict_dirty_i;
    assign deq = mem_wr_valid_o && mem_wr_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            entries_q[wr_ptr_q] <= '{tag:  evict_addr_i[ADDR_WIDTH-1:OFFSET_BITS],
                                     line: evict_line_i};
        end
    end

    assign mem_wr_addr_o = {entries_q[rd_ptr_q].tag, {OFFSET_BITS{1'b0}}};
    assign mem_wr_data_o = entries_q[rd_ptr_q].line;

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
        tags = '0;
        occ  = '0;
        age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tags[i] = entries_q[i].tag;
            age     = PTR_W'(i) - rd_ptr_q;
            occ[i]  = (CNT_W'(age) < count_q);
        end
    end

    wb_lookup #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_lookup (
        .tags_i   (tags),
        .occ_i    (occ),
        .wr_ptr_i (wr_ptr_q),
        .tag_i    (lookup_addr_i[ADDR_WIDTH-1:OFFSET_BITS]),
        .hit_o    (lookup_hit_o),
        .sel_o    (sel)
    );

    always_comb begin
        lookup_line_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) lookup_line_o = lookup_line_o | entries_q[i].line;
        end
    end

    assign unused_offsets = ^{evict_addr_i[OFFSET_BITS-1:0], lookup_addr_i[OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Bench for cache_wb_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_cache_wb_buffer;

    localparam int LW    = 512;
    localparam int AW    = 32;
    localparam int OB    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          evict_valid_i, evict_dirty_i, mem_wr_ready_i;
    logic [AW-1:0] evict_addr_i, lookup_addr_i;
    logic [LW-1:0] evict_line_i;
    logic          evict_ready_o, mem_wr_valid_o, lookup_hit_o, empty_o, full_o;
    logic [AW-1:0] mem_wr_addr_o;
    logic [LW-1:0] mem_wr_data_o, lookup_line_o;
    logic [CW-1:0] count_o;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] q_addr [$];
    logic [LW-1:0] q_line [$];

    cache_wb_buffer #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evict_valid_i(evict_valid_i), .evict_ready_o(evict_ready_o),
        .evict_dirty_i(evict_dirty_i), .evict_addr_i(evict_addr_i), .evict_line_i(evict_line_i),
        .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
        .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o), .lookup_line_o(lookup_line_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~((AW'(1) << OB) - AW'(1));
    endfunction

    // Newest queued victim with the same line address wins.
    task automatic model_lookup(input logic [AW-1:0] a, output logic hit, output logic [LW-1:0] line);
        hit  = 1'b0;
        line = '0;
        for (int i = q_addr.size() - 1; i >= 0; i--) begin
            if (!hit && q_addr[i] == align(a)) begin
                hit  = 1'b1;
                line = q_line[i];
            end
        end
    endtask

    // One clock: the model applies the handshake rules to the inputs held across the edge.
    task automatic step();
        bit d, e;
        @(posedge clk_i);
        if (rst_ni) begin
            d = (q_addr.size() > 0) && mem_wr_ready_i;
            e = evict_valid_i && evict_dirty_i && (q_addr.size() < DEPTH);
            if (d) begin
                void'(q_addr.pop_front());
                void'(q_line.pop_front());
            end
            if (e) begin
                q_addr.push_back(align(evict_addr_i));
                q_line.push_back(evict_line_i);
            end
        end
        #1;
    endtask

    task automatic idle();
        evict_valid_i = 1'b0;
        evict_dirty_i = 1'b0;
        mem_wr_ready_i = 1'b0;
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic dirty);
        evict_valid_i = 1'b1;
        evict_dirty_i = dirty;
        evict_addr_i  = a;
        evict_line_i  = l;
    endtask

    task automatic test_reset();
        idle();
        evict_addr_i = '0; evict_line_i = '0; lookup_addr_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty: got %0b expected 1", empty_o); end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        tests++; if (mem_wr_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", mem_wr_valid_o); end
        tests++; if (evict_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", evict_ready_o); end
        tests++; if (lookup_hit_o !== 1'b0) begin fails++; $display("FAIL reset_hit: got %0b expected 0", lookup_hit_o); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full: got %0b expected 0", full_o); end
    endtask

    task automatic test_single_stall();
        logic [LW-1:0] d = {64{8'hA5}};
        offer(32'h0000_1040, d, 1'b1);
        #1;
        tests++; if (mem_wr_valid_o !== 1'b0) begin fails++; $display("FAIL no_passthru: got %0b expected 0", mem_wr_valid_o); end
        step();
        idle();
        #1;
        tests++; if (mem_wr_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", mem_wr_valid_o); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (mem_wr_addr_o !== 32'h0000_1040) begin fails++; $display("FAIL stall_addr: got %h expected 00001040", mem_wr_addr_o); end
            tests++; if (mem_wr_data_o !== d) begin fails++; $display("FAIL stall_data: got %h expected %h", mem_wr_data_o, d); end
            step();
        end
        mem_wr_ready_i = 1'b1;
        #1;
        step();
        mem_wr_ready_i = 1'b0;
        #1;
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL single_drained: got %0b expected 1", empty_o); end
        tests++; if (mem_wr_valid_o !== 1'b0) begin fails++; $display("FAIL single_valid_off: got %0b expected 0", mem_wr_valid_o); end
    endtask

    task automatic test_clean();
        offer(32'h0000_2000, rand_line(), 1'b0);
        #1;
        tests++; if (evict_ready_o !== 1'b1) begin fails++; $display("FAIL clean_ready: got %0b expected 1", evict_ready_o); end
        step();
        idle();
        #1;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL clean_count: got %0d expected 0", count_o); end
        tests++; if (mem_wr_valid_o !== 1'b0) begin fails++; $display("FAIL clean_valid: got %0b expected 0", mem_wr_valid_o); end
    endtask

    task automatic test_full_wrap();
        logic [AW-1:0] exp_a [4] = '{32'h140, 32'h180, 32'h1C0, 32'h200};
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + AW'(i * 32'h40), rand_line(), 1'b1);
            step();
        end
        idle();
        #1;
        tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL full_flag: got %0b expected 1", full_o); end
        tests++; if (evict_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b expected 0", evict_ready_o); end
        offer(32'h5C0, rand_line(), 1'b1);
        step();
        idle();
        #1;
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_no_enq: got %0d expected 4", count_o); end
        tests++; if (mem_wr_addr_o !== 32'h100) begin fails++; $display("FAIL full_head: got %h expected 00000100", mem_wr_addr_o); end
        mem_wr_ready_i = 1'b1;
        step();
        mem_wr_ready_i = 1'b0;
        #1;
        tests++; if (evict_ready_o !== 1'b1) begin fails++; $display("FAIL full_ready_back: got %0b expected 1", evict_ready_o); end
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL full_count3: got %0d expected 3", count_o); end
        offer(32'h200, rand_line(), 1'b1);
        step();
        idle();
        #1;
        tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL wrap_full: got %0b expected 1", full_o); end
        for (int i = 0; i < 4; i++) begin
            mem_wr_ready_i = 1'b1;
            #1;
            tests++; if (mem_wr_addr_o !== exp_a[i]) begin fails++; $display("FAIL wrap_order: got %h expected %h", mem_wr_addr_o, exp_a[i]); end
            tests++; if (mem_wr_data_o !== q_line[0]) begin fails++; $display("FAIL wrap_data: got %h expected %h", mem_wr_data_o, q_line[0]); end
            step();
        end
        mem_wr_ready_i = 1'b0;
        #1;
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL wrap_empty: got %0b expected 1", empty_o); end
    endtask

    task automatic test_dup_lookup();
        logic [LW-1:0] d1 = rand_line();
        logic [LW-1:0] d2 = rand_line();
        offer(32'h300, d1, 1'b1);
        step();
        offer(32'h300, d2, 1'b1);
        step();
        idle();
        lookup_addr_i = 32'h0000_033C;
        #1;
        tests++; if (lookup_hit_o !== 1'b1) begin fails++; $display("FAIL dup_hit: got %0b expected 1", lookup_hit_o); end
        tests++; if (lookup_line_o !== d2) begin fails++; $display("FAIL dup_newest: got %h expected %h", lookup_line_o, d2); end
        mem_wr_ready_i = 1'b1;
        #1;
        tests++; if (mem_wr_data_o !== d1) begin fails++; $display("FAIL dup_first: got %h expected %h", mem_wr_data_o, d1); end
        step();
        tests++; if (mem_wr_data_o !== d2) begin fails++; $display("FAIL dup_second: got %h expected %h", mem_wr_data_o, d2); end
        step();
        mem_wr_ready_i = 1'b0;
        lookup_addr_i = 32'h400;
        #1;
        tests++; if (lookup_hit_o !== 1'b0) begin fails++; $display("FAIL miss_hit: got %0b expected 0", lookup_hit_o); end
        tests++; if (lookup_line_o !== '0) begin fails++; $display("FAIL miss_line: got %h expected 0", lookup_line_o); end
    endtask

    task automatic test_simul();
        logic [LW-1:0] e1 = rand_line();
        logic [LW-1:0] e2 = rand_line();
        offer(32'h700, e1, 1'b1);
        step();
        offer(32'h740, e2, 1'b1);
        mem_wr_ready_i = 1'b1;
        lookup_addr_i = 32'h740;
        #1;
        tests++; if (lookup_hit_o !== 1'b0) begin fails++; $display("FAIL enq_invisible: got %0b expected 0", lookup_hit_o); end
        lookup_addr_i = 32'h700;
        #1;
        tests++; if (lookup_hit_o !== 1'b1) begin fails++; $display("FAIL head_matchable: got %0b expected 1", lookup_hit_o); end
        tests++; if (lookup_line_o !== e1) begin fails++; $display("FAIL head_line: got %h expected %h", lookup_line_o, e1); end
        tests++; if (mem_wr_addr_o !== 32'h700) begin fails++; $display("FAIL simul_head: got %h expected 00000700", mem_wr_addr_o); end
        lookup_addr_i = 32'h740;
        step();
        idle();
        #1;
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL simul_count: got %0d expected 1", count_o); end
        tests++; if (mem_wr_addr_o !== 32'h740) begin fails++; $display("FAIL simul_new_head: got %h expected 00000740", mem_wr_addr_o); end
        tests++; if (mem_wr_data_o !== e2) begin fails++; $display("FAIL simul_new_data: got %h expected %h", mem_wr_data_o, e2); end
        tests++; if (lookup_hit_o !== 1'b1) begin fails++; $display("FAIL simul_visible: got %0b expected 1", lookup_hit_o); end
        mem_wr_ready_i = 1'b1;
        step();
        idle();
    endtask

    task automatic test_random();
        logic          mhit;
        logic [LW-1:0] mline;
        for (int c = 0; c < 300; c++) begin
            evict_valid_i  = ($urandom_range(0, 9) < 6);
            evict_dirty_i  = ($urandom_range(0, 3) != 0);
            evict_addr_i   = 32'h8000 + AW'($urandom_range(0, 7) << OB) + AW'($urandom_range(0, 63));
            evict_line_i   = rand_line();
            mem_wr_ready_i = ($urandom_range(0, 1) == 1);
            lookup_addr_i  = 32'h8000 + AW'($urandom_range(0, 7) << OB) + AW'($urandom_range(0, 63));
            #1;
            model_lookup(lookup_addr_i, mhit, mline);
            tests++; if (count_o !== CW'(q_addr.size())) begin fails++; $display("FAIL rnd_count: got %0d expected %0d", count_o, q_addr.size()); end
            tests++; if (mem_wr_valid_o !== (q_addr.size() > 0)) begin fails++; $display("FAIL rnd_valid: got %0b expected %0b", mem_wr_valid_o, q_addr.size() > 0); end
            tests++; if (evict_ready_o !== (q_addr.size() < DEPTH)) begin fails++; $display("FAIL rnd_ready: got %0b expected %0b", evict_ready_o, q_addr.size() < DEPTH); end
            if (q_addr.size() > 0) begin
                tests++; if (mem_wr_addr_o !== q_addr[0]) begin fails++; $display("FAIL rnd_addr: got %h expected %h", mem_wr_addr_o, q_addr[0]); end
                tests++; if (mem_wr_data_o !== q_line[0]) begin fails++; $display("FAIL rnd_data: got %h expected %h", mem_wr_data_o, q_line[0]); end
            end
            tests++; if (lookup_hit_o !== mhit) begin fails++; $display("FAIL rnd_hit: got %0b expected %0b", lookup_hit_o, mhit); end
            tests++; if (lookup_line_o !== mline) begin fails++; $display("FAIL rnd_line: got %h expected %h", lookup_line_o, mline); end
            step();
        end
        idle();
        mem_wr_ready_i = 1'b1;
        repeat (DEPTH + 1) step();
        idle();
        #1;
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL rnd_drained: got %0b expected 1", empty_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            offer(32'hA00 + AW'(i * 32'h40), rand_line(), 1'b1);
            step();
        end
        idle();
        lookup_addr_i = 32'hA40;
        #1;
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL pre_reset_count: got %0d expected 3", count_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        q_addr.delete();
        q_line.delete();
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL mid_reset_count: got %0d expected 0", count_o); end
        tests++; if (mem_wr_valid_o !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %0b expected 0", mem_wr_valid_o); end
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL mid_reset_empty: got %0b expected 1", empty_o); end
        tests++; if (evict_ready_o !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %0b expected 1", evict_ready_o); end
        tests++; if (lookup_hit_o !== 1'b0) begin fails++; $display("FAIL mid_reset_hit: got %0b expected 0", lookup_hit_o); end
        step();
        rst_ni = 1'b1;
        step();
        tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL post_reset_empty: got %0b expected 1", empty_o); end
    endtask

    initial begin
        test_reset();
        test_single_stall();
        test_clean();
        test_full_wrap();
        test_dup_lookup();
        test_simul();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
